// File: rtl/uart_button_pkg.sv
// Shared types and constants for the multi-channel button-to-UART trigger.
package uart_button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } tx_state_t;

    localparam logic [7:0] PRESS_BASE   = 8'h41;
    localparam logic [7:0] RELEASE_BASE = 8'h61;
    localparam int         BUSY_TIMEOUT = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, symmetric debounce counter,
// stable level and a one-cycle pulse in the cycle the stable level changes.
module btn_debounce
    import uart_button_pkg::*;
#(
    parameter int DEBOUNCE_W = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_edge
);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  level_q, level_d;
    logic                  edge_q, edge_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  differ;
    logic                  toggle;

    // Counter only advances while the synced pin disagrees with the stable level.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        differ  = (sync2_q != level_q);
        toggle  = differ && (cnt_q == '1);
        cnt_d   = '0;
        if (differ && !toggle) begin
            cnt_d = cnt_q + 1'b1;
        end
        level_d = level_q ^ toggle;
        edge_d  = toggle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_edge  = edge_q;

endmodule

// File: rtl/uart_button_array.sv
// Debounced button array feeding an ASCII event FIFO drained to a UART TX.
// Define UART_BTN_RELEASE_EN to also queue release events as lowercase bytes.
module uart_button_array
    import uart_button_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEBOUNCE_W = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic             i_txBusy,
    output logic             o_enableTx,
    output logic [7:0]       o_bitsTx,
    output logic [N_BTN-1:0] o_level,
    output logic             o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] lvl_edge;
    logic [N_BTN-1:0] rise;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (i_btn[g]),
            .o_level(level[g]),
            .o_edge (lvl_edge[g])
        );
    end

    assign rise = lvl_edge & level;

    logic [N_BTN-1:0] press_pend_q, press_pend_d, press_take, press_keep;
`ifdef UART_BTN_RELEASE_EN
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rel_pend_q, rel_pend_d, rel_take, rel_keep;
    assign fall = lvl_edge & ~level;
`endif
    logic       overflow_q, overflow_d;
    logic       sel_vld;
    logic [7:0] sel_byte;
    logic       push, pop;
    logic       fifo_full, fifo_empty;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          enable_q, enable_d;
    logic [7:0]    bits_q, bits_d;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Lowest channel wins; within a channel the press is served before the release.
    always_comb begin
        sel_vld    = 1'b0;
        sel_byte   = 8'h00;
        press_take = '0;
`ifdef UART_BTN_RELEASE_EN
        rel_take   = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            if (!sel_vld && press_pend_q[i]) begin
                sel_vld       = 1'b1;
                sel_byte      = PRESS_BASE + 8'(i);
                press_take[i] = 1'b1;
            end
`ifdef UART_BTN_RELEASE_EN
            if (!sel_vld && rel_pend_q[i]) begin
                sel_vld     = 1'b1;
                sel_byte    = RELEASE_BASE + 8'(i);
                rel_take[i] = 1'b1;
            end
`endif
        end
        push = sel_vld && !fifo_full;
    end

    // A new edge landing on a flag that is still pending (and not taken now) is lost.
    always_comb begin
        press_keep   = press_pend_q & ~(press_take & {N_BTN{push}});
        press_pend_d = press_keep | rise;
        overflow_d   = overflow_q | (|(rise & press_keep));
`ifdef UART_BTN_RELEASE_EN
        rel_keep     = rel_pend_q & ~(rel_take & {N_BTN{push}});
        rel_pend_d   = rel_keep | fall;
        overflow_d   = overflow_d | (|(fall & rel_keep));
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_byte;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // WAIT_HI gives up after BUSY_TIMEOUT cycles so a silent transmitter cannot stall the queue.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        enable_d = 1'b0;
        bits_d   = bits_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !i_txBusy) begin
                    pop      = 1'b1;
                    enable_d = 1'b1;
                    bits_d   = mem_q[rd_ptr_q];
                    timer_d  = '0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_txBusy) begin
                    state_d = WAIT_LO;
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!i_txBusy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend_q <= '0;
`ifdef UART_BTN_RELEASE_EN
            rel_pend_q   <= '0;
`endif
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            timer_q      <= '0;
            enable_q     <= 1'b0;
            bits_q       <= 8'h00;
        end else begin
            press_pend_q <= press_pend_d;
`ifdef UART_BTN_RELEASE_EN
            rel_pend_q   <= rel_pend_d;
`endif
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            enable_q     <= enable_d;
            bits_q       <= bits_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_enableTx = enable_q;
    assign o_bitsTx   = bits_q;
    assign o_level    = level;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_button_array.sv
// Directed bench for uart_button_array with DEBOUNCE_W=4, N_BTN=4, FIFO_DEPTH=4.
module tb_uart_button_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_btn;
    logic       i_txBusy;
    logic       o_enableTx;
    logic [7:0] o_bitsTx;
    logic [3:0] o_level;
    logic       o_overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int busy_mode = 2;   // 0: busy for 10 cycles after each strobe, 1: stuck high, 2: stuck low
    int busy_cnt  = 0;

    logic [7:0] got[$];
    int         stamp[$];
    logic [7:0] exp_q[$];

    uart_button_array #(
        .N_BTN     (4),
        .DEBOUNCE_W(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn     (i_btn),
        .i_txBusy  (i_txBusy),
        .o_enableTx(o_enableTx),
        .o_bitsTx  (o_bitsTx),
        .o_level   (o_level),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // Strobe monitor and UART busy model, both on the falling edge.
    initial begin
        i_txBusy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy_cnt = 0;
            end else if (o_enableTx) begin
                got.push_back(o_bitsTx);
                stamp.push_back(cyc);
                if (busy_mode == 0) busy_cnt = 10;
            end
            case (busy_mode)
                0: begin
                    i_txBusy = (busy_cnt > 0);
                    if (busy_cnt > 0) busy_cnt--;
                end
                1: i_txBusy = 1'b1;
                default: i_txBusy = 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        i_btn = 4'h0;
        rst   = 1'b1;
        step(1);
        rst   = 1'b0;
        got.delete();
        stamp.delete();
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
        end
    endtask

    function automatic int gap(input int i);
        return (stamp.size() > i) ? stamp[i] - stamp[i-1] : -1;
    endfunction

    initial begin
        rst   = 1'b1;
        i_btn = 4'h0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_enable", 32'(o_enableTx), 0);
        chk("rst_bits", 32'(o_bitsTx), 32'h00);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_overflow", 32'(o_overflow), 0);

        // Glitch: 15 samples high is one short of the 16 synced cycles the counter needs.
        i_btn[2] = 1'b1;
        step(15);
        i_btn[2] = 1'b0;
        step(30);
        chk("glitch_level", 32'(o_level), 0);
        chk("glitch_strobes", 32'(got.size()), 0);

        // Single press: level 18 edges after the pin, strobe three edges later.
        busy_mode = 0;
        do_reset();
        i_btn[2] = 1'b1;
        step(17);
        chk("single_level_early", 32'(o_level), 0);
        step(1);
        chk("single_level", 32'(o_level), 32'h4);
        step(2);
        chk("single_no_strobe_yet", 32'(o_enableTx), 0);
        step(1);
        chk("single_strobe", 32'(o_enableTx), 1);
        chk("single_bits", 32'(o_bitsTx), 32'h43);
        step(9);
        i_btn[2] = 1'b0;
        step(40);
        chk("single_level_rel", 32'(o_level), 0);
`ifdef UART_BTN_RELEASE_EN
        exp_q = '{8'h43, 8'h63};
        chk("single_bits_held", 32'(o_bitsTx), 32'h63);
`else
        exp_q = '{8'h43};
        chk("single_bits_held", 32'(o_bitsTx), 32'h43);
`endif
        chk_seq("single");

        // Simultaneous press: ascending order, each strobe 12 cycles after the previous.
        do_reset();
        i_btn = 4'hF;
        step(100);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        chk_seq("simul");
        for (int i = 1; i < 4; i++) chk($sformatf("simul_gap%0d", i), 32'(gap(i)), 12);

        // Busy never rises: each strobe leaves WAIT_HI by timeout, 17 cycles apart.
        busy_mode = 2;
        do_reset();
        i_btn = 4'hF;
        step(120);
        chk_seq("timeout");
        for (int i = 1; i < 4; i++) chk($sformatf("timeout_gap%0d", i), 32'(gap(i)), 17);

        // Overflow: FIFO full while busy, then a press lands on a still-pending press flag.
        busy_mode = 1;
        do_reset();
        i_btn = 4'hF;
        step(25);
        i_btn = 4'h0;
        step(25);
        chk("ovf_before", 32'(o_overflow), 0);
        i_btn[0] = 1'b1;
        step(25);
        i_btn[0] = 1'b0;
        step(25);
        i_btn[0] = 1'b1;
        step(25);
        chk("ovf_set", 32'(o_overflow), 1);
        i_btn[0] = 1'b0;
        step(25);
        chk("ovf_no_strobe_busy", 32'(got.size()), 0);
        busy_mode = 0;
        step(150);
`ifdef UART_BTN_RELEASE_EN
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41, 8'h61, 8'h62, 8'h63, 8'h64};
`else
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
`endif
        chk_seq("ovf_drain");
        chk("ovf_sticky", 32'(o_overflow), 1);

        // Reset during WAIT_LO of the second strobe, with C and D still queued.
        got.delete();
        stamp.delete();
        i_btn = 4'hF;
        begin
            int n = 0;
            while (got.size() < 2 && n < 200) begin
                step(1);
                n++;
            end
        end
        chk("rmd_two_strobes", 32'(got.size() >= 2), 1);
        step(3);
        do_reset();
        chk("rmd_enable", 32'(o_enableTx), 0);
        chk("rmd_bits", 32'(o_bitsTx), 32'h00);
        chk("rmd_level", 32'(o_level), 0);
        chk("rmd_overflow", 32'(o_overflow), 0);
        step(100);
        chk("rmd_no_strobe", 32'(got.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
